// File: rtl/hdmi_timing_pkg.sv
// Shared raster timing sets (640x480@60, 1280x720@60), derived totals and sync polarities
// for the HDMI video timing generator.
package hdmi_timing_pkg;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } axis_timing_t;

   localparam bit POL_NEG = 1'b0;
   localparam bit POL_POS = 1'b1;

   localparam axis_timing_t H_640X480 = '{active: 640,  fp: 16,  sync: 96, bp: 48};
   localparam axis_timing_t V_640X480 = '{active: 480,  fp: 10,  sync: 2,  bp: 33};
   localparam axis_timing_t H_1280X720 = '{active: 1280, fp: 110, sync: 40, bp: 220};
   localparam axis_timing_t V_1280X720 = '{active: 720,  fp: 5,   sync: 5,  bp: 20};

   function automatic int unsigned axis_total(input axis_timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

   localparam int unsigned H_TOTAL_640X480  = axis_total(H_640X480);
   localparam int unsigned V_TOTAL_640X480  = axis_total(V_640X480);
   localparam int unsigned H_TOTAL_1280X720 = axis_total(H_1280X720);
   localparam int unsigned V_TOTAL_1280X720 = axis_total(V_1280X720);

   localparam bit HS_POL_640X480  = POL_NEG;
   localparam bit VS_POL_640X480  = POL_NEG;
   localparam bit HS_POL_1280X720 = POL_POS;
   localparam bit VS_POL_1280X720 = POL_POS;

endpackage

// File: rtl/hdmi_axis_counter.sv
// Wrapping position counter for one raster axis: synchronous clear, count enable,
// and a combinational terminal-count flag that is high while the count sits at MAX.
module hdmi_axis_counter #(
   parameter int unsigned   W   = 12,
   parameter logic [W-1:0]  MAX = '1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [W-1:0]  cnt_o,
   output logic          tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tc_o  = (cnt_q == MAX);
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// Raster timing generator for the TMDS encoders: pixel request/coordinates one cycle
// ahead of de, with de/hsync/vsync mutually aligned two cycles after the counters.
module hdmi_video_timing_gen
   import hdmi_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_640X480.active,
   parameter int unsigned H_FP     = H_640X480.fp,
   parameter int unsigned H_SYNC   = H_640X480.sync,
   parameter int unsigned H_BP     = H_640X480.bp,
   parameter int unsigned V_ACTIVE = V_640X480.active,
   parameter int unsigned V_FP     = V_640X480.fp,
   parameter int unsigned V_SYNC   = V_640X480.sync,
   parameter int unsigned V_BP     = V_640X480.bp,
   parameter bit          HS_POL   = HS_POL_640X480,
   parameter bit          VS_POL   = VS_POL_640X480,
   parameter int unsigned CNT_W    = 12
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             timing_en,
   output logic             data_req,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             frame_start,
   output logic             de,
   output logic             hsync,
   output logic             vsync
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam longint unsigned CNT_RANGE = 64'(1) << CNT_W;

   localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_width
      $error("hdmi_video_timing_gen: every active/porch/sync width must be at least 1");
   end

   if (longint'(H_TOTAL) > CNT_RANGE || longint'(V_TOTAL) > CNT_RANGE) begin : g_bad_cnt_w
      $error("hdmi_video_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
   end

   // ---------------- raster counters ----------------
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_tc;
   logic             v_tc;
   logic             cnt_clr;

   assign cnt_clr = ~timing_en;

   hdmi_axis_counter #(
      .W   (CNT_W),
      .MAX (H_MAX)
   ) u_h_cnt (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst_n),
      .clr_i  (cnt_clr),
      .en_i   (1'b1),
      .cnt_o  (h_cnt),
      .tc_o   (h_tc)
   );

   hdmi_axis_counter #(
      .W   (CNT_W),
      .MAX (V_MAX)
   ) u_v_cnt (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst_n),
      .clr_i  (cnt_clr),
      .en_i   (h_tc),
      .cnt_o  (v_cnt),
      .tc_o   (v_tc)
   );

   // High while the counters sit at (0,0); tracks the wrap instead of comparing both axes.
   logic origin_q;
   logic origin_d;

   always_comb begin
      origin_d = 1'b0;
      if (!timing_en) begin
         origin_d = 1'b1;
      end else if (h_tc) begin
         origin_d = v_tc;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         origin_q <= 1'b1;
      end else begin
         origin_q <= origin_d;
      end
   end

   // ---------------- region decode ----------------
   logic h_active;
   logic v_active;
   logic h_sync_on;
   logic v_sync_on;

   assign h_active  = (h_cnt < H_ACT_END);
   assign v_active  = (v_cnt < V_ACT_END);
   assign h_sync_on = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
   assign v_sync_on = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

   // ---------------- stage 1: request and coordinates ----------------
   logic             req_q,  req_d;
   logic [CNT_W-1:0] px_q,   px_d;
   logic [CNT_W-1:0] py_q,   py_d;
   logic             fs_q,   fs_d;
   logic             hs1_q,  hs1_d;
   logic             vs1_q,  vs1_d;

   always_comb begin
      req_d = 1'b0;
      px_d  = '0;
      py_d  = '0;
      fs_d  = 1'b0;
      hs1_d = ~HS_POL;
      vs1_d = ~VS_POL;
      if (timing_en) begin
         req_d = h_active && v_active;
         px_d  = h_cnt;
         py_d  = v_cnt;
         fs_d  = origin_q;
         hs1_d = h_sync_on ? HS_POL : ~HS_POL;
         vs1_d = v_sync_on ? VS_POL : ~VS_POL;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         req_q <= 1'b0;
         px_q  <= '0;
         py_q  <= '0;
         fs_q  <= 1'b0;
         hs1_q <= ~HS_POL;
         vs1_q <= ~VS_POL;
      end else begin
         req_q <= req_d;
         px_q  <= px_d;
         py_q  <= py_d;
         fs_q  <= fs_d;
         hs1_q <= hs1_d;
         vs1_q <= vs1_d;
      end
   end

   // ---------------- stage 2: encoder-facing controls ----------------
   // Stage 2 always drains stage 1, so disabling never chops a pulse mid-cycle.
   logic de_q;
   logic hs2_q;
   logic vs2_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         de_q  <= 1'b0;
         hs2_q <= ~HS_POL;
         vs2_q <= ~VS_POL;
      end else begin
         de_q  <= req_q;
         hs2_q <= hs1_q;
         vs2_q <= vs1_q;
      end
   end

   assign data_req    = req_q;
   assign pixel_x     = px_q;
   assign pixel_y     = py_q;
   assign frame_start = fs_q;
   assign de          = de_q;
   assign hsync       = hs2_q;
   assign vsync       = vs2_q;

endmodule
